// File: rtl/ysyx_2022040010_mul_ctrl.sv
// ysyx_2022040010_mul_ctrl: sequencer between execute and the multicycle
// multiplier. Decodes one RV64M multiply op, holds the operands for LATENCY
// cycles, captures the product and presents it with its tag until accepted.
// Optional last-result cache: define YSYX_2022040010_MUL_CACHE_EN.
module ysyx_2022040010_mul_ctrl #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned TAG_W   = 5
) (
  input  logic             clk,
  input  logic             ret,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic             in_word,
  input  logic [63:0]      in_a,
  input  logic [63:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic             mul_ina_s,
  output logic             mul_inb_s,
  output logic [63:0]      mul_ina,
  output logic [63:0]      mul_inb,
  output logic [2:0]       mul_sel_hilo,
  input  logic [63:0]      mul_result,
  input  logic             mul_over
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_LO   = 3'b100;
  localparam logic [2:0] SEL_HI   = 3'b010;
  localparam logic [2:0] SEL_W    = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               out_valid_q, out_valid_d;
  logic [63:0]        out_result_q, out_result_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;
  logic               busy_q, busy_d;
  logic               ina_s_q, ina_s_d;
  logic               inb_s_q, inb_s_d;
  logic [63:0]        ina_q, ina_d;
  logic [63:0]        inb_q, inb_d;
  logic [2:0]         sel_q, sel_d;

  logic               accept;
  logic               capture;
  logic               hit;
  logic [63:0]        hit_res;
  logic [2:0]         dec_sel;
  logic               dec_as;
  logic               dec_bs;

  assign in_ready = ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready)) & ~flush;
  assign accept   = in_valid & in_ready;
  assign capture  = (state_q == S_BUSY) & (cnt_q == CNT_LAST);

`ifdef YSYX_2022040010_MUL_CACHE_EN
  logic               c_vld_q, c_vld_d;
  logic [63:0]        c_a_q, c_a_d;
  logic [63:0]        c_b_q, c_b_d;
  logic [63:0]        c_res_q, c_res_d;
  logic [1:0]         c_op_q, c_op_d;
  logic               c_word_q, c_word_d;
  logic [1:0]         op_q, op_d;
  logic               word_q, word_d;

  assign hit = c_vld_q & (c_a_q == in_a) & (c_b_q == in_b) &
               (c_op_q == in_op) & (c_word_q == in_word);
  assign hit_res = c_res_q;
`else
  assign hit     = 1'b0;
  assign hit_res = '0;
`endif

  // Op decode: signedness and product-half select.
  always_comb begin
    dec_sel = SEL_HI;
    dec_as  = 1'b0;
    dec_bs  = 1'b0;
    if (in_word) begin
      dec_sel = SEL_W;
    end else begin
      unique case (in_op)
        2'b00:   begin dec_sel = SEL_LO; dec_as = 1'b1; dec_bs = 1'b1; end
        2'b01:   begin dec_sel = SEL_HI; dec_as = 1'b1; dec_bs = 1'b1; end
        2'b10:   begin dec_sel = SEL_HI; dec_as = 1'b1; dec_bs = 1'b0; end
        default: begin dec_sel = SEL_HI; dec_as = 1'b0; dec_bs = 1'b0; end
      endcase
    end
  end

  // State and window-counter registers.
  always_ff @(posedge clk or negedge ret) begin
    if (!ret) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: flush beats accept, accept beats capture/retire.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (accept) begin
      state_d = hit ? S_DONE : S_BUSY;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_BUSY: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (capture) state_d = S_DONE;
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  // Next values of the registered outputs, operand holds and cache entry.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    ina_s_d      = ina_s_q;
    inb_s_d      = inb_s_q;
    ina_d        = ina_q;
    inb_d        = inb_q;
    sel_d        = sel_q;
    busy_d       = (state_d != S_IDLE);
`ifdef YSYX_2022040010_MUL_CACHE_EN
    c_vld_d  = c_vld_q;
    c_a_d    = c_a_q;
    c_b_d    = c_b_q;
    c_res_d  = c_res_q;
    c_op_d   = c_op_q;
    c_word_d = c_word_q;
    op_d     = op_q;
    word_d   = word_q;
`endif
    if (flush) begin
      out_valid_d = 1'b0;
      sel_d       = SEL_NONE;
    end else if (accept) begin
      out_tag_d = in_tag;
      if (hit) begin
        out_valid_d  = 1'b1;
        out_result_d = hit_res;
      end else begin
        out_valid_d = 1'b0;
        ina_d       = in_a;
        inb_d       = in_b;
        ina_s_d     = dec_as;
        inb_s_d     = dec_bs;
        sel_d       = dec_sel;
`ifdef YSYX_2022040010_MUL_CACHE_EN
        op_d   = in_op;
        word_d = in_word;
`endif
      end
    end else if (capture) begin
      out_valid_d  = 1'b1;
      out_result_d = mul_over ? mul_result : 64'd0;
      sel_d        = SEL_NONE;
`ifdef YSYX_2022040010_MUL_CACHE_EN
      c_vld_d  = 1'b1;
      c_a_d    = ina_q;
      c_b_d    = inb_q;
      c_op_d   = op_q;
      c_word_d = word_q;
      c_res_d  = mul_over ? mul_result : 64'd0;
`endif
    end else if ((state_q == S_DONE) && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output and operand-hold registers.
  always_ff @(posedge clk or negedge ret) begin
    if (!ret) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      busy_q       <= 1'b0;
      ina_s_q      <= 1'b0;
      inb_s_q      <= 1'b0;
      ina_q        <= '0;
      inb_q        <= '0;
      sel_q        <= SEL_NONE;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
      busy_q       <= busy_d;
      ina_s_q      <= ina_s_d;
      inb_s_q      <= inb_s_d;
      ina_q        <= ina_d;
      inb_q        <= inb_d;
      sel_q        <= sel_d;
    end
  end

`ifdef YSYX_2022040010_MUL_CACHE_EN
  // Last-result cache entry; survives flush, cleared only by reset.
  always_ff @(posedge clk or negedge ret) begin
    if (!ret) begin
      c_vld_q  <= 1'b0;
      c_a_q    <= '0;
      c_b_q    <= '0;
      c_res_q  <= '0;
      c_op_q   <= '0;
      c_word_q <= 1'b0;
      op_q     <= '0;
      word_q   <= 1'b0;
    end else begin
      c_vld_q  <= c_vld_d;
      c_a_q    <= c_a_d;
      c_b_q    <= c_b_d;
      c_res_q  <= c_res_d;
      c_op_q   <= c_op_d;
      c_word_q <= c_word_d;
      op_q     <= op_d;
      word_q   <= word_d;
    end
  end
`endif

  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_tag      = out_tag_q;
  assign busy         = busy_q;
  assign mul_ina_s    = ina_s_q;
  assign mul_inb_s    = inb_s_q;
  assign mul_ina      = ina_q;
  assign mul_inb      = inb_q;
  assign mul_sel_hilo = sel_q;

endmodule
